// File: rtl/hpdcache_pkg.sv
// Shared constants and ID-split helpers for the memory write arbiter.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_MEM_WR_NREQ       = 2;
    localparam int unsigned HPDCACHE_MEM_WR_ID_W       = 8;
    localparam int unsigned HPDCACHE_MEM_WR_META_W     = 64;
    localparam int unsigned HPDCACHE_MEM_WR_DATA_W     = 512;
    localparam int unsigned HPDCACHE_MEM_WR_ORDER_DEPTH = 4;

    function automatic int unsigned hpdcache_src_id_w(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_mem_wr_arbiter_if.sv
// Requester-side and memory-side bundles of the memory write arbiter.
interface hpdcache_mem_wr_arbiter_req_if
    import hpdcache_pkg::*;
#(
    parameter int unsigned NREQ       = HPDCACHE_MEM_WR_NREQ,
    parameter int unsigned MemIdWidth = HPDCACHE_MEM_WR_ID_W,
    parameter int unsigned MetaWidth  = HPDCACHE_MEM_WR_META_W,
    parameter int unsigned DataWidth  = HPDCACHE_MEM_WR_DATA_W
);
    localparam int unsigned SrcIdWidth = hpdcache_src_id_w(NREQ);
    localparam int unsigned ReqIdWidth = MemIdWidth - SrcIdWidth;

    logic [NREQ-1:0]                  req_valid_i;
    logic [NREQ-1:0]                  req_ready_o;
    logic [NREQ-1:0][MetaWidth-1:0]   req_meta_i;
    logic [NREQ-1:0][ReqIdWidth-1:0]  req_id_i;
    logic [NREQ-1:0]                  req_data_valid_i;
    logic [NREQ-1:0]                  req_data_ready_o;
    logic [NREQ-1:0][DataWidth-1:0]   req_data_i;
    logic [NREQ-1:0][DataWidth/8-1:0] req_be_i;
    logic [NREQ-1:0]                  req_last_i;
    logic [NREQ-1:0]                  resp_valid_o;
    logic [NREQ-1:0]                  resp_ready_i;
    logic [ReqIdWidth-1:0]            resp_id_o;
    logic                             resp_error_o;

    modport master (
        output req_valid_i, req_meta_i, req_id_i,
        output req_data_valid_i, req_data_i, req_be_i, req_last_i,
        output resp_ready_i,
        input  req_ready_o, req_data_ready_o,
        input  resp_valid_o, resp_id_o, resp_error_o
    );

    modport slave (
        input  req_valid_i, req_meta_i, req_id_i,
        input  req_data_valid_i, req_data_i, req_be_i, req_last_i,
        input  resp_ready_i,
        output req_ready_o, req_data_ready_o,
        output resp_valid_o, resp_id_o, resp_error_o
    );
endinterface

interface hpdcache_mem_wr_arbiter_mem_if
    import hpdcache_pkg::*;
#(
    parameter int unsigned MemIdWidth = HPDCACHE_MEM_WR_ID_W,
    parameter int unsigned MetaWidth  = HPDCACHE_MEM_WR_META_W,
    parameter int unsigned DataWidth  = HPDCACHE_MEM_WR_DATA_W
);
    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [MetaWidth-1:0]   mem_req_meta_o;
    logic [MemIdWidth-1:0]  mem_req_id_o;
    logic                   mem_data_valid_o;
    logic                   mem_data_ready_i;
    logic [DataWidth-1:0]   mem_data_o;
    logic [DataWidth/8-1:0] mem_be_o;
    logic                   mem_last_o;
    logic                   mem_resp_valid_i;
    logic                   mem_resp_ready_o;
    logic [MemIdWidth-1:0]  mem_resp_id_i;
    logic                   mem_resp_error_i;

    modport master (
        output mem_req_valid_o, mem_req_meta_o, mem_req_id_o,
        output mem_data_valid_o, mem_data_o, mem_be_o, mem_last_o,
        output mem_resp_ready_o,
        input  mem_req_ready_i, mem_data_ready_i,
        input  mem_resp_valid_i, mem_resp_id_i, mem_resp_error_i
    );

    modport slave (
        input  mem_req_valid_o, mem_req_meta_o, mem_req_id_o,
        input  mem_data_valid_o, mem_data_o, mem_be_o, mem_last_o,
        input  mem_resp_ready_o,
        output mem_req_ready_i, mem_data_ready_i,
        output mem_resp_valid_i, mem_resp_id_i, mem_resp_error_i
    );
endinterface

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO; depth need not be a power of two.
module hpdcache_fifo_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [CntW-1:0]  r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CntW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rd];
    // Full is judged before any pop of the same cycle
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr <= (r_wr == PtrW'(DEPTH - 1)) ? '0 : PtrW'(r_wr + PtrW'(1));
            end
            if (w_pop) begin
                r_rd <= (r_rd == PtrW'(DEPTH - 1)) ? '0 : PtrW'(r_rd + PtrW'(1));
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= CntW'(r_cnt + CntW'(1));
                2'b01:   r_cnt <= CntW'(r_cnt - CntW'(1));
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/hpdcache_mem_wr_arbiter.sv
// Merges N memory write requesters: RR metadata arbitration with lock,
// data kept in metadata order via an order FIFO, responses routed by ID.
module hpdcache_mem_wr_arbiter
    import hpdcache_pkg::*;
#(
    parameter int unsigned NREQ       = HPDCACHE_MEM_WR_NREQ,
    parameter int unsigned MemIdWidth = HPDCACHE_MEM_WR_ID_W,
    parameter int unsigned MetaWidth  = HPDCACHE_MEM_WR_META_W,
    parameter int unsigned DataWidth  = HPDCACHE_MEM_WR_DATA_W,
    parameter int unsigned OrderDepth = HPDCACHE_MEM_WR_ORDER_DEPTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    hpdcache_mem_wr_arbiter_req_if.slave  req,
    hpdcache_mem_wr_arbiter_mem_if.master mem
);
    localparam int unsigned SrcIdWidth = hpdcache_src_id_w(NREQ);
    localparam int unsigned ReqIdWidth = MemIdWidth - SrcIdWidth;

    typedef logic [SrcIdWidth-1:0] src_t;

    if (SrcIdWidth >= MemIdWidth) begin : g_bad_id_split
        $error("SrcIdWidth must be smaller than MemIdWidth");
    end

    src_t r_ptr;
    src_t r_gnt;
    logic r_lock;

    src_t w_idx;
    src_t w_rr;
    src_t w_gnt;
    src_t w_head;
    src_t w_src;
    logic w_src_ok;
    logic w_full;
    logic w_empty;
    logic w_req_vld;
    logic w_push;
    logic w_data_vld;
    logic w_pop;

    // Descending scan so the closest requester after r_ptr wins
    always_comb begin
        w_idx = r_ptr;
        w_rr  = r_ptr;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            w_idx = src_t'((int'(r_ptr) + i) % int'(NREQ));
            if (req.req_valid_i[w_idx]) begin
                w_rr = w_idx;
            end
        end
    end

    assign w_gnt     = r_lock ? r_gnt : w_rr;
    assign w_req_vld = rst_ni & (|req.req_valid_i) & ~w_full;
    assign w_push    = w_req_vld & mem.mem_req_ready_i;

    assign mem.mem_req_valid_o = w_req_vld;
    assign mem.mem_req_meta_o  = req.req_meta_i[w_gnt];
    assign mem.mem_req_id_o    = {w_gnt, req.req_id_i[w_gnt]};

    always_comb begin
        req.req_ready_o        = '0;
        req.req_ready_o[w_gnt] = rst_ni & mem.mem_req_ready_i & ~w_full;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_lock <= 1'b0;
        end else if (w_push) begin
            r_ptr  <= (w_gnt == src_t'(NREQ - 1)) ? '0 : src_t'(w_gnt + src_t'(1));
            r_lock <= 1'b0;
        end else if (w_req_vld) begin
            r_gnt  <= w_gnt;
            r_lock <= 1'b1;
        end
    end

    hpdcache_fifo_reg #(
        .WIDTH (SrcIdWidth),
        .DEPTH (OrderDepth)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_gnt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_data_vld = rst_ni & ~w_empty & req.req_data_valid_i[w_head];
    assign w_pop      = w_data_vld & mem.mem_data_ready_i & req.req_last_i[w_head];

    assign mem.mem_data_valid_o = w_data_vld;
    assign mem.mem_data_o       = req.req_data_i[w_head];
    assign mem.mem_be_o         = req.req_be_i[w_head];
    assign mem.mem_last_o       = req.req_last_i[w_head];

    always_comb begin
        req.req_data_ready_o         = '0;
        req.req_data_ready_o[w_head] = rst_ni & mem.mem_data_ready_i & ~w_empty;
    end

    assign w_src    = mem.mem_resp_id_i[MemIdWidth-1 -: SrcIdWidth];
    assign w_src_ok = ({1'b0, w_src} < (SrcIdWidth + 1)'(NREQ));

    // Responses to a non-existent source are swallowed
    always_comb begin
        req.resp_valid_o = '0;
        if (w_src_ok) begin
            req.resp_valid_o[w_src] = rst_ni & mem.mem_resp_valid_i;
        end
    end

    assign mem.mem_resp_ready_o = rst_ni & (w_src_ok ? req.resp_ready_i[w_src] : 1'b1);
    assign req.resp_id_o        = mem.mem_resp_id_i[ReqIdWidth-1:0];
    assign req.resp_error_o     = mem.mem_resp_error_i;

    a_resp_src_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem.mem_resp_valid_i |-> w_src_ok
    );
endmodule

// File: tb/tb_hpdcache_mem_wr_arbiter.sv
// Directed bench for the memory write arbiter (NREQ=2, OrderDepth=4).
module tb_hpdcache_mem_wr_arbiter;
    import hpdcache_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned IDW   = 8;
    localparam int unsigned METAW = 64;
    localparam int unsigned DW    = 512;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hpdcache_mem_wr_arbiter_req_if #(
        .NREQ(NREQ), .MemIdWidth(IDW), .MetaWidth(METAW), .DataWidth(DW)
    ) u_req_if ();

    hpdcache_mem_wr_arbiter_mem_if #(
        .MemIdWidth(IDW), .MetaWidth(METAW), .DataWidth(DW)
    ) u_mem_if ();

    hpdcache_mem_wr_arbiter #(
        .NREQ(NREQ), .MemIdWidth(IDW), .MetaWidth(METAW),
        .DataWidth(DW), .OrderDepth(DEPTH)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req    (u_req_if),
        .mem    (u_mem_if)
    );

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        u_req_if.req_valid_i      = 2'b11;
        u_req_if.req_meta_i[0]    = 64'h1000;
        u_req_if.req_meta_i[1]    = 64'h2000;
        u_req_if.req_id_i[0]      = 7'h11;
        u_req_if.req_id_i[1]      = 7'h22;
        u_req_if.req_data_valid_i = 2'b11;
        u_req_if.req_data_i[0]    = {8{64'hD0D0_0000_0000_0001}};
        u_req_if.req_data_i[1]    = {8{64'hD1D1_0000_0000_0002}};
        u_req_if.req_be_i[0]      = 64'hFFFF_FFFF_FFFF_FFFF;
        u_req_if.req_be_i[1]      = 64'h0F0F_0F0F_0F0F_0F0F;
        u_req_if.req_last_i       = 2'b11;
        u_req_if.resp_ready_i     = 2'b11;
        u_mem_if.mem_req_ready_i  = 1'b1;
        u_mem_if.mem_data_ready_i = 1'b1;
        u_mem_if.mem_resp_valid_i = 1'b1;
        u_mem_if.mem_resp_id_i    = 8'h00;
        u_mem_if.mem_resp_error_i = 1'b0;

        repeat (2) tick();
        #1;
        check("rst_req_ready", u_req_if.req_ready_o, 2'b00);
        check("rst_data_ready", u_req_if.req_data_ready_o, 2'b00);
        check("rst_mem_req_valid", u_mem_if.mem_req_valid_o, 1'b0);
        check("rst_mem_data_valid", u_mem_if.mem_data_valid_o, 1'b0);
        check("rst_resp_valid", u_req_if.resp_valid_o, 2'b00);
        check("rst_mem_resp_ready", u_mem_if.mem_resp_ready_o, 1'b0);

        u_req_if.req_data_valid_i = 2'b00;
        u_req_if.req_last_i       = 2'b00;
        u_mem_if.mem_data_ready_i = 1'b0;
        u_mem_if.mem_resp_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check("first_valid", u_mem_if.mem_req_valid_o, 1'b1);
        check("first_ready", u_req_if.req_ready_o, 2'b01);
        check("first_id", u_mem_if.mem_req_id_o, 8'h11);
        check("first_meta", u_mem_if.mem_req_meta_o, 64'h1000);

        tick();
        check("alt1_id", u_mem_if.mem_req_id_o, 8'hA2);
        check("alt1_ready", u_req_if.req_ready_o, 2'b10);
        check("alt1_meta", u_mem_if.mem_req_meta_o, 64'h2000);
        tick();
        check("alt2_id", u_mem_if.mem_req_id_o, 8'h11);
        tick();
        check("alt3_id", u_mem_if.mem_req_id_o, 8'hA2);
        tick();
        check("full_req_valid", u_mem_if.mem_req_valid_o, 1'b0);
        check("full_req_ready", u_req_if.req_ready_o, 2'b00);

        u_req_if.req_data_valid_i = 2'b01;
        u_req_if.req_last_i       = 2'b01;
        u_mem_if.mem_data_ready_i = 1'b1;
        #1;
        check("pop_data_valid", u_mem_if.mem_data_valid_o, 1'b1);
        check("pop_data_ready", u_req_if.req_data_ready_o, 2'b01);
        check("pop_data_lo", u_mem_if.mem_data_o[63:0], 64'hD0D0_0000_0000_0001);
        check("pop_push_blocked", u_mem_if.mem_req_valid_o, 1'b0);
        tick();
        u_req_if.req_data_valid_i = 2'b00;
        #1;
        check("fifth_valid", u_mem_if.mem_req_valid_o, 1'b1);
        check("fifth_id", u_mem_if.mem_req_id_o, 8'h11);
        check("fifth_ready", u_req_if.req_ready_o, 2'b01);
        tick();
        check("refull_valid", u_mem_if.mem_req_valid_o, 1'b0);

        rst_n = 1'b0;
        u_req_if.req_valid_i = 2'b00;
        tick();
        rst_n = 1'b1;
        u_req_if.req_data_valid_i = 2'b11;
        #1;
        check("rst_flush_data_valid", u_mem_if.mem_data_valid_o, 1'b0);
        check("rst_flush_data_ready", u_req_if.req_data_ready_o, 2'b00);
        u_req_if.req_data_valid_i = 2'b00;

        u_req_if.req_valid_i     = 2'b10;
        u_mem_if.mem_req_ready_i = 1'b0;
        #1;
        check("lock_id0", u_mem_if.mem_req_id_o, 8'hA2);
        check("lock_ready0", u_req_if.req_ready_o, 2'b00);
        tick();
        u_req_if.req_valid_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_hold_id", u_mem_if.mem_req_id_o, 8'hA2);
            check("lock_hold_meta", u_mem_if.mem_req_meta_o, 64'h2000);
            tick();
        end
        u_mem_if.mem_req_ready_i  = 1'b1;
        u_req_if.req_data_valid_i = 2'b10;
        u_req_if.req_last_i       = 2'b10;
        u_mem_if.mem_data_ready_i = 1'b0;
        #1;
        check("lock_hs_id", u_mem_if.mem_req_id_o, 8'hA2);
        check("lock_hs_ready", u_req_if.req_ready_o, 2'b10);
        check("no_bypass", u_mem_if.mem_data_valid_o, 1'b0);
        tick();
        check("data_next_cycle", u_mem_if.mem_data_valid_o, 1'b1);
        check("after_lock_id", u_mem_if.mem_req_id_o, 8'h11);
        check("after_lock_ready", u_req_if.req_ready_o, 2'b01);
        tick();
        u_req_if.req_valid_i      = 2'b00;
        u_mem_if.mem_data_ready_i = 1'b1;
        #1;
        check("drain1_ready", u_req_if.req_data_ready_o, 2'b10);
        tick();
        u_req_if.req_data_valid_i = 2'b00;
        u_req_if.req_valid_i      = 2'b10;
        #1;
        check("meta1_id", u_mem_if.mem_req_id_o, 8'hA2);
        tick();
        u_req_if.req_valid_i = 2'b00;

        u_req_if.req_data_valid_i = 2'b10;
        u_req_if.req_last_i       = 2'b10;
        #1;
        check("order_stall_valid", u_mem_if.mem_data_valid_o, 1'b0);
        check("order_stall_ready", u_req_if.req_data_ready_o, 2'b01);
        tick();
        u_req_if.req_data_valid_i = 2'b11;
        u_req_if.req_data_i[0]    = {8{64'hBEA7_0000_0000_000A}};
        #1;
        check("beatA_valid", u_mem_if.mem_data_valid_o, 1'b1);
        check("beatA_data", u_mem_if.mem_data_o[511:448], 64'hBEA7_0000_0000_000A);
        check("beatA_last", u_mem_if.mem_last_o, 1'b0);
        tick();
        u_req_if.req_data_i[0] = {8{64'hBEA7_0000_0000_000B}};
        u_req_if.req_last_i    = 2'b11;
        #1;
        check("beatB_data", u_mem_if.mem_data_o[63:0], 64'hBEA7_0000_0000_000B);
        check("beatB_last", u_mem_if.mem_last_o, 1'b1);
        check("beatB_ready", u_req_if.req_data_ready_o, 2'b01);
        tick();
        check("req1_data_valid", u_mem_if.mem_data_valid_o, 1'b1);
        check("req1_data_ready", u_req_if.req_data_ready_o, 2'b10);
        check("req1_data", u_mem_if.mem_data_o[63:0], 64'hD1D1_0000_0000_0002);
        check("req1_be", u_mem_if.mem_be_o, 64'h0F0F_0F0F_0F0F_0F0F);
        tick();
        check("drained_valid", u_mem_if.mem_data_valid_o, 1'b0);
        u_req_if.req_data_valid_i = 2'b00;

        u_mem_if.mem_resp_valid_i = 1'b1;
        u_mem_if.mem_resp_id_i    = 8'h85;
        u_mem_if.mem_resp_error_i = 1'b1;
        u_req_if.resp_ready_i     = 2'b01;
        #1;
        check("resp85_valid", u_req_if.resp_valid_o, 2'b10);
        check("resp85_id", u_req_if.resp_id_o, 7'h05);
        check("resp85_err", u_req_if.resp_error_o, 1'b1);
        check("resp85_ready_lo", u_mem_if.mem_resp_ready_o, 1'b0);
        u_req_if.resp_ready_i = 2'b10;
        #1;
        check("resp85_ready_hi", u_mem_if.mem_resp_ready_o, 1'b1);
        u_mem_if.mem_resp_id_i    = 8'h07;
        u_mem_if.mem_resp_error_i = 1'b0;
        #1;
        check("resp07_valid", u_req_if.resp_valid_o, 2'b01);
        check("resp07_id", u_req_if.resp_id_o, 7'h07);
        check("resp07_ready", u_mem_if.mem_resp_ready_o, 1'b0);
        u_mem_if.mem_resp_valid_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hpdcache_mem_wr_arbiter.md
Name: hpdcache_mem_wr_arbiter

Overview:
Merges N independent memory write requesters into the single cache-level memory write interface. Requesters are the write buffer wrapper, the uncacheable/AMO controller and future flush engines. It arbitrates the request-metadata channel, keeps the data channel in the same order as the metadata channel through an order FIFO, and routes write responses back by ID. It sits directly downstream of the write buffer wrapper's mem_req_write / mem_req_write_data channels and upstream of the memory interface.

Parameters:
NREQ, 2, number of requesters (≥2)
MemIdWidth, 8, memory ID width on the output side
SrcIdWidth, $clog2(NREQ), source-index bits prepended to the ID (localparam)
ReqIdWidth, MemIdWidth-SrcIdWidth, ID width on the requester side (localparam)
MetaWidth, 64, packed request metadata width, excluding ID
DataWidth, 512, write data width; BE width is DataWidth/8
OrderDepth, 4, order FIFO depth (≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  metadata valid per requester
req_ready_o  out  NREQ  metadata ready per requester
req_meta_i  in  NREQ×MetaWidth  metadata per requester
req_id_i  in  NREQ×ReqIdWidth  transaction ID per requester
req_data_valid_i  in  NREQ  data valid per requester
req_data_ready_o  out  NREQ  data ready per requester
req_data_i  in  NREQ×DataWidth  write data
req_be_i  in  NREQ×DataWidth/8  byte enables
req_last_i  in  NREQ  last data beat
resp_valid_o  out  NREQ  response valid per requester
resp_ready_i  in  NREQ  response ready per requester
resp_id_o  out  ReqIdWidth  response ID, source bits stripped (shared)
resp_error_o  out  1  response error (shared)
mem_req_valid_o  out  1  metadata to memory
mem_req_ready_i  in  1
mem_req_meta_o  out  MetaWidth
mem_req_id_o  out  MemIdWidth  {src_idx, req_id}
mem_data_valid_o  out  1
mem_data_ready_i  in  1
mem_data_o  out  DataWidth
mem_be_o  out  DataWidth/8
mem_last_o  out  1
mem_resp_valid_i  in  1
mem_resp_ready_o  out  1
mem_resp_id_i  in  MemIdWidth
mem_resp_error_i  in  1

Behaviour:
- Reset: round-robin pointer = 0, lock = 0, order FIFO empty. All valid/ready outputs are 0 while rst_ni is low. Reset mid-burst discards FIFO contents; no recovery is required.
- Metadata arbitration:
  - Round-robin, starting from the requester after the last granted one.
  - mem_req_valid_o = (any req_valid_i) & !fifo_full.
  - If mem_req_valid_o is high and mem_req_ready_i is low, set lock and hold the grant until the handshake. A valid request is never switched away from (AXI stability).
  - req_ready_o[g] = mem_req_ready_i & !fifo_full; the other bits are 0.
  - On the handshake: push g into the order FIFO, advance the pointer to g+1 mod NREQ, clear lock.
- Data channel:
  - h = FIFO head. mem_data_valid_o = !fifo_empty & req_data_valid_i[h].
  - req_data_ready_o[h] = mem_data_ready_i & !fifo_empty.
  - Data and BE are muxed from h.
  - Pop on a data handshake with req_last_i[h] = 1. Multi-beat bursts stay on h until last.
- No bypass: data can be accepted at the earliest one cycle after its metadata handshake.
- Push and pop in the same cycle on a full FIFO: the pop is processed, and the push is blocked because fifo_full is evaluated pre-pop.
- Response routing:
  - s = mem_resp_id_i[MemIdWidth-1 -: SrcIdWidth].
  - resp_valid_o[s] = mem_resp_valid_i; mem_resp_ready_o = resp_ready_i[s].
  - resp_id_o = low ReqIdWidth bits of mem_resp_id_i.
  - The response path is purely combinational, with no state.
  - s ≥ NREQ: response is dropped (ready = 1) and a simulation assertion fires.
- Pointer and FIFO index wrap-around are modulo NREQ and OrderDepth. OrderDepth need not be a power of 2.
- Assertions:
  - SrcIdWidth < MemIdWidth.
  - No req_data_valid_i high for a requester with no pending entry is required; such data simply waits.

Decomposition:
- Requester-count/ID-split helper constants go in hpdcache_pkg.
- The order FIFO is a natural sub-module: hpdcache_fifo_reg (width SrcIdWidth, depth OrderDepth).
- The round-robin arbiter with lock is built inline or with hpdcache_rrarb.

Test Plan:
- Reset: hold rst_ni = 0 with all inputs valid → every valid/ready output 0; after release, first grant goes to requester 0.
- Both requesters assert meta every cycle, mem_req_ready_i = 1 → grants alternate 0,1,0,1; mem_req_id_o = {0,id0}, {1,id1}.
- Requester 1 granted, mem_req_ready_i low 3 cycles while requester 0 raises valid → grant and meta stay on 1 until the handshake.
- Metas accepted 0 then 1; requester 1 offers data first → data 1 stalls until requester 0's 2-beat burst ends with last; then 1 passes.
- Order FIFO filled (OrderDepth=4 metas, no data) → mem_req_valid_o = 0; after one data pop, the fifth meta is accepted the next cycle.
- mem_resp_id_i = 8'h85 (NREQ=2) → resp_valid_o = 2'b10, resp_id_o = 7'h05; resp_ready_i[1] = 0 gives mem_resp_ready_o = 0.
